// File: rtl/sb_1m2s.sv
// sb_1m2s: simple-bus address decoder, one master to two slaves plus an internal decode-error responder.
// One outstanding read and one outstanding write; responses are steered back from the slave that took the request.
module sb_1m2s #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hF000_0000,
    parameter logic [31:0] S1_BASE = 32'h1000_0000,
    parameter logic [31:0] S1_MASK = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sb_arvalid_m,
    output logic        sb_arready_m,
    input  logic [31:0] sb_araddr_m,
    output logic        sb_rvalid_m,
    input  logic        sb_rready_m,
    output logic [31:0] sb_rdata_m,
    input  logic        sb_wvalid_m,
    output logic        sb_wready_m,
    input  logic [31:0] sb_waddr_m,
    input  logic [31:0] sb_wdata_m,
    input  logic [3:0]  sb_wstrb_m,
    output logic        sb_bvalid_m,
    input  logic        sb_bready_m,
    output logic        sb_bresp_m,
    output logic        sb_arvalid_s0,
    input  logic        sb_arready_s0,
    output logic [31:0] sb_araddr_s0,
    input  logic        sb_rvalid_s0,
    output logic        sb_rready_s0,
    input  logic [31:0] sb_rdata_s0,
    output logic        sb_wvalid_s0,
    input  logic        sb_wready_s0,
    output logic [31:0] sb_waddr_s0,
    output logic [31:0] sb_wdata_s0,
    output logic [3:0]  sb_wstrb_s0,
    input  logic        sb_bvalid_s0,
    output logic        sb_bready_s0,
    input  logic        sb_bresp_s0,
    output logic        sb_arvalid_s1,
    input  logic        sb_arready_s1,
    output logic [31:0] sb_araddr_s1,
    input  logic        sb_rvalid_s1,
    output logic        sb_rready_s1,
    input  logic [31:0] sb_rdata_s1,
    output logic        sb_wvalid_s1,
    input  logic        sb_wready_s1,
    output logic [31:0] sb_waddr_s1,
    output logic [31:0] sb_wdata_s1,
    output logic [3:0]  sb_wstrb_s1,
    input  logic        sb_bvalid_s1,
    output logic        sb_bready_s1,
    input  logic        sb_bresp_s1
);
    typedef enum logic [1:0] {S0, S1, ERR} sel_t;

    logic rbusy_q, rbusy_d, wbusy_q, wbusy_d;
    sel_t rsel_q, rsel_d, wsel_q, wsel_d, ar_sel, w_sel;
    logic r_done, ar_done, r_blk, b_done, w_done, w_blk;

    assign sb_araddr_s0 = sb_araddr_m;
    assign sb_araddr_s1 = sb_araddr_m;
    assign sb_waddr_s0  = sb_waddr_m;
    assign sb_waddr_s1  = sb_waddr_m;
    assign sb_wdata_s0  = sb_wdata_m;
    assign sb_wdata_s1  = sb_wdata_m;
    assign sb_wstrb_s0  = sb_wstrb_m;
    assign sb_wstrb_s1  = sb_wstrb_m;

    always_comb begin
        ar_sel = ((sb_araddr_m & S0_MASK) == S0_BASE) ? S0 :
                 ((sb_araddr_m & S1_MASK) == S1_BASE) ? S1 : ERR;
        // a response completing this cycle frees the path for a zero-bubble follow-on request
        sb_rvalid_m  = rbusy_q & (rsel_q == ERR ? 1'b1 : rsel_q == S0 ? sb_rvalid_s0 : sb_rvalid_s1);
        sb_rdata_m   = rsel_q == ERR ? 32'h0 : rsel_q == S0 ? sb_rdata_s0 : sb_rdata_s1;
        sb_rready_s0 = rbusy_q & (rsel_q == S0) & sb_rready_m;
        sb_rready_s1 = rbusy_q & (rsel_q == S1) & sb_rready_m;
        r_done       = sb_rvalid_m & sb_rready_m;
        r_blk        = rbusy_q & ~r_done;
        sb_arvalid_s0 = ~r_blk & sb_arvalid_m & (ar_sel == S0);
        sb_arvalid_s1 = ~r_blk & sb_arvalid_m & (ar_sel == S1);
        sb_arready_m  = ~r_blk & sb_arvalid_m &
                        (ar_sel == ERR ? 1'b1 : ar_sel == S0 ? sb_arready_s0 : sb_arready_s1);
        ar_done = sb_arvalid_m & sb_arready_m;
        rbusy_d = ar_done ? 1'b1 : r_done ? 1'b0 : rbusy_q;
        rsel_d  = ar_done ? ar_sel : rsel_q;
    end

    always_comb begin
        w_sel = ((sb_waddr_m & S0_MASK) == S0_BASE) ? S0 :
                ((sb_waddr_m & S1_MASK) == S1_BASE) ? S1 : ERR;
        sb_bvalid_m  = wbusy_q & (wsel_q == ERR ? 1'b1 : wsel_q == S0 ? sb_bvalid_s0 : sb_bvalid_s1);
        sb_bresp_m   = wsel_q == ERR ? 1'b1 : wsel_q == S0 ? sb_bresp_s0 : sb_bresp_s1;
        sb_bready_s0 = wbusy_q & (wsel_q == S0) & sb_bready_m;
        sb_bready_s1 = wbusy_q & (wsel_q == S1) & sb_bready_m;
        b_done       = sb_bvalid_m & sb_bready_m;
        w_blk        = wbusy_q & ~b_done;
        sb_wvalid_s0 = ~w_blk & sb_wvalid_m & (w_sel == S0);
        sb_wvalid_s1 = ~w_blk & sb_wvalid_m & (w_sel == S1);
        sb_wready_m  = ~w_blk & sb_wvalid_m &
                       (w_sel == ERR ? 1'b1 : w_sel == S0 ? sb_wready_s0 : sb_wready_s1);
        w_done  = sb_wvalid_m & sb_wready_m;
        wbusy_d = w_done ? 1'b1 : b_done ? 1'b0 : wbusy_q;
        wsel_d  = w_done ? w_sel : wsel_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbusy_q <= 1'b0;
            rsel_q  <= S0;
            wbusy_q <= 1'b0;
            wsel_q  <= S0;
        end else begin
            rbusy_q <= rbusy_d;
            rsel_q  <= rsel_d;
            wbusy_q <= wbusy_d;
            wsel_q  <= wsel_d;
        end
    end
endmodule

// File: tb/tb_sb_1m2s.sv
// tb_sb_1m2s: directed-vector bench for the sb_1m2s decoder with hand-computed expectations.
module tb_sb_1m2s;
    logic clk = 0, rst = 1;
    logic arvalid_m = 0, rready_m = 0, wvalid_m = 0, bready_m = 0;
    logic [31:0] araddr_m = 0, waddr_m = 0, wdata_m = 0;
    logic [3:0] wstrb_m = 0;
    logic arready_m, rvalid_m, wready_m, bvalid_m, bresp_m;
    logic [31:0] rdata_m;
    logic arready_s0 = 0, rvalid_s0 = 0, wready_s0 = 0, bvalid_s0 = 0, bresp_s0 = 1;
    logic arready_s1 = 0, rvalid_s1 = 0, wready_s1 = 0, bvalid_s1 = 0, bresp_s1 = 0;
    logic [31:0] rdata_s0 = 32'h11, rdata_s1 = 32'h22;
    logic arvalid_s0, rready_s0, wvalid_s0, bready_s0, arvalid_s1, rready_s1, wvalid_s1, bready_s1;
    logic [31:0] araddr_s0, araddr_s1, waddr_s0, waddr_s1, wdata_s0, wdata_s1;
    logic [3:0] wstrb_s0, wstrb_s1;
    int total = 0, passed = 0;

    sb_1m2s dut (
        .clk(clk), .rst(rst),
        .sb_arvalid_m(arvalid_m), .sb_arready_m(arready_m), .sb_araddr_m(araddr_m),
        .sb_rvalid_m(rvalid_m), .sb_rready_m(rready_m), .sb_rdata_m(rdata_m),
        .sb_wvalid_m(wvalid_m), .sb_wready_m(wready_m), .sb_waddr_m(waddr_m),
        .sb_wdata_m(wdata_m), .sb_wstrb_m(wstrb_m),
        .sb_bvalid_m(bvalid_m), .sb_bready_m(bready_m), .sb_bresp_m(bresp_m),
        .sb_arvalid_s0(arvalid_s0), .sb_arready_s0(arready_s0), .sb_araddr_s0(araddr_s0),
        .sb_rvalid_s0(rvalid_s0), .sb_rready_s0(rready_s0), .sb_rdata_s0(rdata_s0),
        .sb_wvalid_s0(wvalid_s0), .sb_wready_s0(wready_s0), .sb_waddr_s0(waddr_s0),
        .sb_wdata_s0(wdata_s0), .sb_wstrb_s0(wstrb_s0),
        .sb_bvalid_s0(bvalid_s0), .sb_bready_s0(bready_s0), .sb_bresp_s0(bresp_s0),
        .sb_arvalid_s1(arvalid_s1), .sb_arready_s1(arready_s1), .sb_araddr_s1(araddr_s1),
        .sb_rvalid_s1(rvalid_s1), .sb_rready_s1(rready_s1), .sb_rdata_s1(rdata_s1),
        .sb_wvalid_s1(wvalid_s1), .sb_wready_s1(wready_s1), .sb_waddr_s1(waddr_s1),
        .sb_wdata_s1(wdata_s1), .sb_wstrb_s1(wstrb_s1),
        .sb_bvalid_s1(bvalid_s1), .sb_bready_s1(bready_s1), .sb_bresp_s1(bresp_s1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_arready", arready_m, 0);
        check("rst_rvalid", rvalid_m, 0);
        check("rst_wready", wready_m, 0);
        check("rst_bvalid", bvalid_m, 0);
        check("rst_arvalid_s0", arvalid_s0, 0);
        check("rst_rdata", rdata_m, 32'h11);
        check("rst_bresp", bresp_m, 1);
        step();
        rst = 0;
        // read to slave 0, response two cycles later
        araddr_m = 32'h10; arvalid_m = 1; arready_s0 = 1; #1;
        check("t1_arvalid_s0", arvalid_s0, 1);
        check("t1_arvalid_s1", arvalid_s1, 0);
        check("t1_arready", arready_m, 1);
        check("t1_araddr_s1", araddr_s1, 32'h10);
        step();
        arvalid_m = 0; arready_s0 = 0; #1;
        check("t1_wait_rvalid", rvalid_m, 0);
        check("t1_wait_arvalid_s1", arvalid_s1, 0);
        step();
        rvalid_s0 = 1; rdata_s0 = 32'hA5A5_0001; rready_m = 1; #1;
        check("t1_rvalid", rvalid_m, 1);
        check("t1_rdata", rdata_m, 32'hA5A5_0001);
        check("t1_rready_s0", rready_s0, 1);
        check("t1_rready_s1", rready_s1, 0);
        step();
        rvalid_s0 = 0; rready_m = 0; rvalid_s1 = 1; #1;
        check("t1_stray_rvalid", rvalid_m, 0);
        rvalid_s1 = 0;
        // write to slave 1
        waddr_m = 32'h1000_0004; wdata_m = 32'h1234_5678; wstrb_m = 4'b0011; wvalid_m = 1; wready_s1 = 1; #1;
        check("t2_wvalid_s1", wvalid_s1, 1);
        check("t2_wvalid_s0", wvalid_s0, 0);
        check("t2_wready", wready_m, 1);
        check("t2_wdata_s1", wdata_s1, 32'h1234_5678);
        check("t2_wstrb_s0", wstrb_s0, 4'b0011);
        step();
        wvalid_m = 0; wready_s1 = 0; bvalid_s1 = 1; bresp_s1 = 0; #1;
        check("t2_bvalid", bvalid_m, 1);
        check("t2_bresp", bresp_m, 0);
        check("t2_bready_s1_hold", bready_s1, 0);
        step();
        check("t2_bvalid_held", bvalid_m, 1);
        bready_m = 1; #1;
        check("t2_bready_s1", bready_s1, 1);
        step();
        bready_m = 0; #1;
        check("t2_wbusy_clear", bvalid_m, 0);
        bvalid_s1 = 0;
        // unmapped read and write
        araddr_m = 32'h2000_0000; arvalid_m = 1; #1;
        check("t3_arready", arready_m, 1);
        check("t3_arvalid_s0", arvalid_s0, 0);
        check("t3_arvalid_s1", arvalid_s1, 0);
        step();
        arvalid_m = 0; #1;
        check("t3_rvalid", rvalid_m, 1);
        check("t3_rdata", rdata_m, 0);
        step();
        check("t3_rvalid_held", rvalid_m, 1);
        rready_m = 1;
        step();
        rready_m = 0; #1;
        check("t3_rvalid_clear", rvalid_m, 0);
        waddr_m = 32'h3000_0000; wvalid_m = 1; #1;
        check("t3_wready", wready_m, 1);
        step();
        wvalid_m = 0; #1;
        check("t3_bvalid", bvalid_m, 1);
        check("t3_bresp", bresp_m, 1);
        bready_m = 1;
        step();
        bready_m = 0;
        // back-to-back reads s0 then s1
        rready_m = 1; arready_s0 = 1; arready_s1 = 1; araddr_m = 32'h100; arvalid_m = 1; #1;
        check("t4_ar0", arready_m, 1);
        step();
        araddr_m = 32'h1000_0100; rvalid_s0 = 1; rdata_s0 = 32'hD0; #1;
        check("t4_rdata0", rdata_m, 32'hD0);
        check("t4_arvalid_s1", arvalid_s1, 1);
        check("t4_ar1_same_cycle", arready_m, 1);
        step();
        arvalid_m = 0; rvalid_s0 = 0; rvalid_s1 = 1; rdata_s1 = 32'hD1; #1;
        check("t4_rvalid1", rvalid_m, 1);
        check("t4_rdata1", rdata_m, 32'hD1);
        step();
        rvalid_s1 = 0; rready_m = 0;
        // second read blocked behind pending first
        araddr_m = 32'h200; arvalid_m = 1; #1;
        check("t5_ar0", arready_m, 1);
        step();
        araddr_m = 32'h1000_0200; rvalid_s0 = 1; #1;
        check("t5_blk_arready", arready_m, 0);
        check("t5_blk_arvalid_s1", arvalid_s1, 0);
        step();
        check("t5_blk2_arready", arready_m, 0);
        rready_m = 1; #1;
        check("t5_unblk_arvalid_s1", arvalid_s1, 1);
        check("t5_unblk_arready", arready_m, 1);
        step();
        arvalid_m = 0; rvalid_s0 = 0; rready_m = 0; rvalid_s1 = 1; #1;
        check("t6_pending_s1", rvalid_m, 1);
        // reset while slave 1 read is pending
        rst = 1; #1;
        check("t6_rst_rvalid", rvalid_m, 0);
        step();
        rst = 0; #1;
        check("t6_late_rvalid", rvalid_m, 0);
        rvalid_s1 = 0;
        araddr_m = 32'h40; arvalid_m = 1; #1;
        check("t6_ar0", arready_m, 1);
        step();
        arvalid_m = 0; rvalid_s0 = 1; rdata_s0 = 32'h77; rready_m = 1; #1;
        check("t6_rvalid", rvalid_m, 1);
        check("t6_rdata", rdata_m, 32'h77);
        step();
        rvalid_s0 = 0; rready_m = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
